pcs_40g_tx_sched: RTL and testbench
===================================

PCS_40G_TX_SCHED -- requirements
Module: pcs_40g_tx_sched

Interface
REQ-001 SHALL have parameter GAP_N, default 16383, number of data slots between consecutive alignment-marker (AM) slots.
REQ-002 SHALL have parameter SEQ_N, default 33, gearbox sequence length in cycles; the last cycle of each sequence is a stall cycle.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port nreset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port valid_i  input  1  MAC presents a 4-lane block this cycle.
REQ-006 SHALL have port ready_o  output  1  PCS accepts the MAC block this cycle.
REQ-007 SHALL have port am_v_o  output  1  this cycle is an AM slot; the encoder emits markers on all 4 lanes.
REQ-008 SHALL have port stall_o  output  1  gearbox stall cycle; the encoder emits nothing.
REQ-009 SHALL have port idle_fill_o  output  1  data slot with no MAC block; the encoder emits idle blocks.
REQ-010 SHALL have port seq_o  output  $clog2(SEQ_N)  current gearbox sequence index.
REQ-011 SHALL have port gap_o  output  $clog2(GAP_N+1)  current AM gap index.
REQ-012 SHALL have port ovf_o  output  1  sticky flag: MAC offered valid_i while ready_o=0.

Function
REQ-013 SHALL hold registers seq_q (0..SEQ_N-1), gap_q (0..GAP_N) and ovf_q; seq_o=seq_q, gap_o=gap_q, ovf_o=ovf_q.
REQ-014 SHALL classify each non-reset cycle from current register values only (Moore, zero-cycle latency), with this priority:
REQ-015 - STALL: seq_q==SEQ_N-1; stall_o=1, am_v_o=0, ready_o=0, idle_fill_o=0.
REQ-016 - AM: not STALL and gap_q==GAP_N; am_v_o=1, ready_o=0, stall_o=0, idle_fill_o=0.
REQ-017 - DATA: otherwise; ready_o=1; idle_fill_o=!valid_i; am_v_o=0, stall_o=0.
REQ-018 SHALL advance seq_q every non-reset cycle: SEQ_N-1 wraps to 0, else +1.
REQ-019 SHALL leave gap_q unchanged in STALL, set gap_q to 0 in AM, and increment it in DATA.
REQ-020 SHALL, when an AM slot coincides with a STALL cycle, defer the AM to the next non-stall cycle without losing it.
REQ-021 SHALL count a MAC block as transferred only when valid_i=1 and ready_o=1 in the same cycle.
REQ-022 SHALL set ovf_q when valid_i=1 and ready_o=0 outside reset, and hold it until reset.
REQ-023 SHALL let the MAC hold valid_i high across stall and AM cycles; the block is taken on the next DATA cycle.
REQ-024 SHALL size counters exactly to $clog2 widths with no unreachable state; out-of-range values SHALL never be produced.

Reset
REQ-025 SHALL, in every cycle with nreset=1, load seq_q=0, gap_q=GAP_N and ovf_q=0.
REQ-026 SHALL, while nreset=1, force ready_o=0, am_v_o=0, stall_o=0 and idle_fill_o=0, and ignore valid_i.
REQ-027 SHALL make the first cycle after reset release an AM slot (seq_o=0, gap_o=GAP_N).
REQ-028 SHALL, on reset asserted mid-sequence or mid-gap, discard all progress and restart from the state given in REQ-025 on release.

Verification
REQ-029 SHALL cover default parameters with valid_i=1 held: release reset -> cycle 0 has am_v_o=1; ready_o=1 on cycles 1..31; cycle 32 has stall_o=1 with seq_o=32; seq_o=0 on cycle 33; exactly one am_v_o per 16384 non-stall cycles.
REQ-030 SHALL cover the AM/stall collision with GAP_N=31, SEQ_N=33: cycle 0 is AM, cycles 1..31 are DATA (gap_o 0..30), cycle 32 is STALL with gap_o=31, cycle 33 is AM, cycle 34 is DATA with gap_o=0.
REQ-031 SHALL cover idle fill with GAP_N=4: valid_i=0 on cycle 2 -> idle_fill_o=1, ready_o=1 on cycle 2; idle_fill_o=0 on all AM and stall cycles.
REQ-032 SHALL cover overflow: valid_i=1 on reset-release cycle 0 (an AM cycle) -> ovf_o=1 from cycle 1 and stays 1 until nreset=1.
REQ-033 SHALL cover mid-run reset: assert nreset at cycle 20 for 2 cycles -> all outputs 0, ovf_o cleared; the first cycle after release is AM with seq_o=0.
REQ-034 SHALL cover a long run of 3*GAP_N cycles with GAP_N=4 and random valid_i: count of accepted blocks equals the count of cycles with valid_i&&ready_o; no cycle has more than one of am_v_o, stall_o, ready_o set.

Source files
------------

// File: rtl/pcs_40g_tx_sched_if.sv
// pcs_40g_tx_sched_if
//   Handshake/slot bundle between the MAC-facing side and the 40G PCS
//   transmit scheduler.
//   valid_i     : MAC presents a 4-lane block this cycle
//   ready_o     : PCS accepts the MAC block this cycle
//   am_v_o      : alignment-marker slot, markers on all 4 lanes
//   stall_o     : gearbox stall cycle, encoder emits nothing
//   idle_fill_o : data slot without a MAC block, encoder emits idles
//   master modport = MAC side, slave modport = scheduler side.
interface pcs_40g_tx_sched_if;
   logic valid_i;
   logic ready_o;
   logic am_v_o;
   logic stall_o;
   logic idle_fill_o;

   modport master (
      output valid_i,
      input  ready_o,
      input  am_v_o,
      input  stall_o,
      input  idle_fill_o
   );

   modport slave (
      input  valid_i,
      output ready_o,
      output am_v_o,
      output stall_o,
      output idle_fill_o
   );
endinterface

// File: rtl/pcs_40g_tx_sched.sv
// pcs_40g_tx_sched
//   Transmit slot scheduler for a 4-lane 40G PCS. Every cycle is classified
//   as a gearbox STALL, an alignment-marker (AM) slot or a DATA slot, from
//   the current counter values only (Moore decode, zero-cycle latency).
//   A stall has priority over an AM; because the gap counter does not move
//   during a stall, a colliding AM is simply deferred to the next cycle.
// Ports
//   clk    : clock, rising edge
//   nreset : synchronous, active-high reset
//   mac    : handshake/slot bundle (slave side), see pcs_40g_tx_sched_if
//   seq_o  : gearbox sequence index, 0..SEQ_N-1
//   gap_o  : AM gap index, 0..GAP_N (GAP_N means the next slot is AM)
//   ovf_o  : sticky, MAC offered a block while ready_o was low
module pcs_40g_tx_sched #(
   parameter int GAP_N = 16383,
   parameter int SEQ_N = 33
) (
   input  logic                       clk,
   input  logic                       nreset,
   pcs_40g_tx_sched_if.slave          mac,
   output logic [$clog2(SEQ_N)-1:0]   seq_o,
   output logic [$clog2(GAP_N+1)-1:0] gap_o,
   output logic                       ovf_o
);

   localparam int SW = $clog2(SEQ_N);
   localparam int GW = $clog2(GAP_N + 1);

   localparam logic [SW-1:0] SEQ_ZERO = SW'(0);
   localparam logic [SW-1:0] SEQ_ONE  = SW'(1);
   localparam logic [SW-1:0] SEQ_LAST = SW'(SEQ_N - 1);
   localparam logic [GW-1:0] GAP_ZERO = GW'(0);
   localparam logic [GW-1:0] GAP_ONE  = GW'(1);
   localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_N);

   typedef enum logic [1:0] {
      SLOT_DATA  = 2'd0,
      SLOT_AM    = 2'd1,
      SLOT_STALL = 2'd2
   } slot_e;

   logic [SW-1:0] seq_q;
   logic [GW-1:0] gap_q;
   logic          ovf_q;

   logic [SW-1:0] seq_next_s;
   logic [GW-1:0] gap_next_s;
   logic          ovf_next_s;
   slot_e         slot_s;
   logic          ready_s;
   logic          am_s;
   logic          stall_s;
   logic          idle_s;

   // Slot classification: stall outranks AM, AM outranks data.
   always_comb begin
      slot_s = SLOT_DATA;
      if (seq_q == SEQ_LAST) begin
         slot_s = SLOT_STALL;
      end else if (gap_q == GAP_MAX) begin
         slot_s = SLOT_AM;
      end else begin
         slot_s = SLOT_DATA;
      end
   end

   // Slot outputs, all forced low while reset is asserted.
   always_comb begin
      ready_s = 1'b0;
      am_s    = 1'b0;
      stall_s = 1'b0;
      idle_s  = 1'b0;
      if (nreset) begin
         ready_s = 1'b0;
      end else begin
         case (slot_s)
            SLOT_STALL: stall_s = 1'b1;
            SLOT_AM:    am_s    = 1'b1;
            SLOT_DATA: begin
               ready_s = 1'b1;
               idle_s  = ~mac.valid_i;
            end
            default:    stall_s = 1'b0;
         endcase
      end
   end

   // Next-state: sequence always advances, gap freezes on stall so a
   // colliding AM is held over rather than lost.
   always_comb begin
      seq_next_s = seq_q;
      gap_next_s = gap_q;
      ovf_next_s = ovf_q;
      if (nreset) begin
         seq_next_s = SEQ_ZERO;
         gap_next_s = GAP_MAX;
         ovf_next_s = 1'b0;
      end else begin
         if (seq_q == SEQ_LAST) begin
            seq_next_s = SEQ_ZERO;
         end else begin
            seq_next_s = seq_q + SEQ_ONE;
         end
         case (slot_s)
            SLOT_STALL: gap_next_s = gap_q;
            SLOT_AM:    gap_next_s = GAP_ZERO;
            SLOT_DATA:  gap_next_s = gap_q + GAP_ONE;
            default:    gap_next_s = GAP_MAX;
         endcase
         if (mac.valid_i && !ready_s) begin
            ovf_next_s = 1'b1;
         end else begin
            ovf_next_s = ovf_q;
         end
      end
   end

   // Counter and sticky-flag registers.
   always_ff @(posedge clk) begin
      seq_q <= seq_next_s;
      gap_q <= gap_next_s;
      ovf_q <= ovf_next_s;
   end

   assign mac.ready_o     = ready_s;
   assign mac.am_v_o      = am_s;
   assign mac.stall_o     = stall_s;
   assign mac.idle_fill_o = idle_s;
   assign seq_o           = seq_q;
   assign gap_o           = gap_q;
   assign ovf_o           = ovf_q;

endmodule

// File: tb/tb_pcs_40g_tx_sched.sv
// tb_pcs_40g_tx_sched
//   Three scheduler instances (default GAP_N, GAP_N=31, GAP_N=4; SEQ_N=33)
//   run side by side. The reference model tracks only "cycles since reset
//   release" and "non-stall cycles since release": a cycle is a stall when
//   its index mod SEQ_N is SEQ_N-1, and the k-th non-stall slot is an AM
//   when k mod (GAP_N+1) is 0. Expected outputs are queued by the driver
//   and popped/compared by an independent monitor on the falling edge.
module tb_pcs_40g_tx_sched;
   localparam int S  = 33;
   localparam int G0 = 16383;
   localparam int G1 = 31;
   localparam int G2 = 4;

   typedef struct {
      int ready;
      int am;
      int stall;
      int idle;
      int seq;
      int gap;
      int ovf;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic nreset;
   logic vld [3];

   pcs_40g_tx_sched_if if0 ();
   pcs_40g_tx_sched_if if1 ();
   pcs_40g_tx_sched_if if2 ();

   logic [5:0]  seq0, seq1, seq2;
   logic [13:0] gap0;
   logic [4:0]  gap1;
   logic [2:0]  gap2;
   logic        ovf0, ovf1, ovf2;

   assign if0.valid_i = vld[0];
   assign if1.valid_i = vld[1];
   assign if2.valid_i = vld[2];

   pcs_40g_tx_sched #(.GAP_N(G0), .SEQ_N(S)) u_d0 (
      .clk(clk), .nreset(nreset), .mac(if0), .seq_o(seq0), .gap_o(gap0), .ovf_o(ovf0));
   pcs_40g_tx_sched #(.GAP_N(G1), .SEQ_N(S)) u_d1 (
      .clk(clk), .nreset(nreset), .mac(if1), .seq_o(seq1), .gap_o(gap1), .ovf_o(ovf1));
   pcs_40g_tx_sched #(.GAP_N(G2), .SEQ_N(S)) u_d2 (
      .clk(clk), .nreset(nreset), .mac(if2), .seq_o(seq2), .gap_o(gap2), .ovf_o(ovf2));

   int rdy_a [3];
   int am_a  [3];
   int st_a  [3];
   int idl_a [3];
   int seq_a [3];
   int gap_a [3];
   int ovf_a [3];

   always_comb begin
      rdy_a[0] = int'(if0.ready_o);  rdy_a[1] = int'(if1.ready_o);  rdy_a[2] = int'(if2.ready_o);
      am_a[0]  = int'(if0.am_v_o);   am_a[1]  = int'(if1.am_v_o);   am_a[2]  = int'(if2.am_v_o);
      st_a[0]  = int'(if0.stall_o);  st_a[1]  = int'(if1.stall_o);  st_a[2]  = int'(if2.stall_o);
      idl_a[0] = int'(if0.idle_fill_o); idl_a[1] = int'(if1.idle_fill_o); idl_a[2] = int'(if2.idle_fill_o);
      seq_a[0] = int'(seq0); seq_a[1] = int'(seq1); seq_a[2] = int'(seq2);
      gap_a[0] = int'(gap0); gap_a[1] = int'(gap1); gap_a[2] = int'(gap2);
      ovf_a[0] = int'(ovf0); ovf_a[1] = int'(ovf1); ovf_a[2] = int'(ovf2);
   end

   // Scoreboard, model state and statistics
   exp_t sbq [3][$];
   int   m_n   [3];
   int   m_k   [3];
   int   m_ovf [3];
   int   m_acc [3];
   int   m_am  [3];
   int   o_acc [3];
   int   o_am  [3];
   int   vectors = 0;
   int   miscompares = 0;

   function automatic int gp(int i);
      case (i)
         0:       return G0;
         1:       return G1;
         default: return G2;
      endcase
   endfunction

   task automatic chk(string nm, int i, int act, int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s inst%0d t=%0t got %0d expected %0d", nm, i, $time, act, req);
      end
   endtask

   // Expected outputs of the current cycle from the abstract state.
   function automatic exp_t model_out(int i, bit rst, bit v);
      exp_t e;
      int   g;
      int   r;
      bit   st;
      bit   am;
      g      = gp(i);
      r      = m_k[i] % (g + 1);
      e.seq  = m_n[i] % S;
      e.gap  = (r == 0) ? g : r - 1;
      e.ovf  = m_ovf[i];
      st     = (e.seq == S - 1);
      am     = !st && (r == 0);
      e.stall = rst ? 0 : int'(st);
      e.am    = rst ? 0 : int'(am);
      e.ready = rst ? 0 : int'(!st && !am);
      e.idle  = rst ? 0 : int'(!st && !am && !v);
      return e;
   endfunction

   task automatic model_step(int i, bit rst, bit v);
      int g;
      bit st;
      bit am;
      bit dat;
      if (rst) begin
         m_n[i]   = 0;
         m_k[i]   = 0;
         m_ovf[i] = 0;
      end else begin
         g   = gp(i);
         st  = ((m_n[i] % S) == S - 1);
         am  = !st && ((m_k[i] % (g + 1)) == 0);
         dat = !st && !am;
         if (dat && v) m_acc[i]++;
         if (am) m_am[i]++;
         if (!dat && v) m_ovf[i] = 1;
         if (!st) m_k[i]++;
         m_n[i]++;
      end
   endtask

   task automatic drive(bit rst, bit v0, bit v1, bit v2);
      @(posedge clk);
      #1;
      nreset = rst;
      vld[0] = v0;
      vld[1] = v1;
      vld[2] = v2;
      for (int i = 0; i < 3; i++) begin
         sbq[i].push_back(model_out(i, rst, vld[i]));
         model_step(i, rst, vld[i]);
      end
   endtask

   function automatic bit rnd();
      return ($urandom_range(0, 3) != 0);
   endfunction

   // Monitor: compare every presented cycle against the queued expectation.
   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         if (sbq[i].size() > 0) begin
            e = sbq[i].pop_front();
            chk("ready", i, rdy_a[i], e.ready);
            chk("am_v",  i, am_a[i],  e.am);
            chk("stall", i, st_a[i],  e.stall);
            chk("idle",  i, idl_a[i], e.idle);
            chk("seq",   i, seq_a[i], e.seq);
            chk("gap",   i, gap_a[i], e.gap);
            chk("ovf",   i, ovf_a[i], e.ovf);
            chk("excl",  i, int'((rdy_a[i] + am_a[i] + st_a[i]) <= 1), 1);
            if (vld[i] && rdy_a[i] == 1) o_acc[i]++;
            if (am_a[i] == 1) o_am[i]++;
         end
      end
   end

   initial begin
      nreset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         vld[i]   = 1'b0;
         m_n[i]   = 0;
         m_k[i]   = 0;
         m_ovf[i] = 0;
         m_acc[i] = 0;
         m_am[i]  = 0;
         o_acc[i] = 0;
         o_am[i]  = 0;
      end

      // Reset with valid offered: must be ignored.
      for (int c = 0; c < 3; c++) drive(1'b1, 1'b1, rnd(), rnd());

      // Long run: default instance with valid held high, others random.
      for (int c = 0; c < 17000; c++) drive(1'b0, 1'b1, rnd(), rnd());
      @(negedge clk);
      #1;
      // 17000 cycles hold 16485 non-stall slots: AMs at slot 0 and 16384.
      chk("am_count_default", 0, o_am[0], 2);

      // Mid-run reset after 20 cycles, held 2 cycles with valid high.
      for (int c = 0; c < 20; c++) drive(1'b0, rnd(), rnd(), rnd());
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      // Valid on the release cycle (an AM slot) must raise the sticky flag.
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      for (int c = 0; c < 120; c++) drive(1'b0, rnd(), rnd(), $urandom_range(0, 1) == 1);

      // Reset again and run with no early valid, then a random tail.
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 8; c++) drive(1'b0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 200; c++) drive(1'b0, rnd(), rnd(), rnd());

      @(negedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("accepted", i, o_acc[i], m_acc[i]);
         chk("am_count", i, o_am[i], m_am[i]);
         chk("sb_drain", i, sbq[i].size(), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
